// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the performance counter CSR port.
// Holds the counter CSR address bases and the port FSM state type.
package core_config_pkg;

  localparam int XLEN         = 32;
  localparam int PERF_CNT_LEN = 64;

  localparam logic [11:0] CSR_CNT_U_LO = 12'hC00;
  localparam logic [11:0] CSR_CNT_U_HI = 12'hC80;
  localparam logic [11:0] CSR_CNT_M_LO = 12'hB00;
  localparam logic [11:0] CSR_CNT_M_HI = 12'hB80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } perf_port_state_t;

endpackage

// File: rtl/perf_csr_port_if.sv
// Request/response handshake between the execute stage (master) and the
// performance counter CSR port (slave).
interface perf_csr_port_if;
  import core_config_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [11:0]     req_addr;
  logic            req_write;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/perf_csr_decode.sv
// Combinational decode of a counter CSR address into counter index, half
// select and legality (user halves are read-only, mtime is not mapped).
module perf_csr_decode
  import core_config_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int IDX_W   = 2
) (
  input  logic [11:0]      addr,
  input  logic             write,
  output logic [IDX_W-1:0] index,
  output logic             hi,
  output logic             legal,
  output logic             writable
);

  localparam logic [6:0] NUM_CNT_L = 7'(NUM_CNT);

  logic [11:0] base;
  logic        is_user;
  logic        is_mach;
  logic        in_range;
  logic        is_mtime;

  // Classify the address block and bound the counter offset
  always_comb begin
    base     = {addr[11:7], 7'b000_0000};
    is_user  = (base == CSR_CNT_U_LO) || (base == CSR_CNT_U_HI);
    is_mach  = (base == CSR_CNT_M_LO) || (base == CSR_CNT_M_HI);
    in_range = (addr[6:0] < NUM_CNT_L);
    is_mtime = is_mach && (addr[6:0] == 7'd1);
    hi       = addr[7];
    index    = addr[IDX_W-1:0];
    writable = is_mach && in_range && !is_mtime;
    legal    = (is_user && in_range && !write) || writable;
  end

endmodule

// File: rtl/perf_csr_port.sv
// CSR access port for the performance counter bank: split 64-bit reads with a
// high-half coherence shadow, and one-cycle load strobes for machine writes.
module perf_csr_port
  import core_config_pkg::*;
#(
  parameter int NUM_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  perf_csr_port_if.slave          bus,
  input  logic [NUM_CNT*XLEN-1:0] cnt_lo,
  input  logic [NUM_CNT*XLEN-1:0] cnt_hi,
  output logic [NUM_CNT-1:0]      cnt_wr_en,
  output logic                    cnt_wr_hi,
  output logic [XLEN-1:0]         cnt_wr_data
);

  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  perf_port_state_t state_q;
  logic [11:0]      addr_q;
  logic             write_q;
  logic [XLEN-1:0]  wdata_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [XLEN-1:0]  rsp_rdata_q;
  logic             rsp_err_q;
  logic [NUM_CNT-1:0] wr_en_q;
  logic             wr_hi_q;
  logic [XLEN-1:0]  wr_data_q;
  logic [XLEN-1:0]  shadow_q;
  logic [IDX_W-1:0] shadow_idx_q;
  logic             shadow_vld_q;

  logic [IDX_W-1:0]   dec_idx;
  logic               dec_hi;
  logic               dec_legal;
  logic               dec_writable;
  logic [XLEN-1:0]    lo_arr [NUM_CNT];
  logic [XLEN-1:0]    hi_arr [NUM_CNT];
  logic [XLEN-1:0]    lo_sel;
  logic [XLEN-1:0]    hi_sel;
  logic               shadow_hit;
  logic [XLEN-1:0]    rdata_d;
  logic [NUM_CNT-1:0] wr_en_d;

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_unpack
    assign lo_arr[g] = cnt_lo[g*XLEN +: XLEN];
    assign hi_arr[g] = cnt_hi[g*XLEN +: XLEN];
  end

  perf_csr_decode #(.NUM_CNT(NUM_CNT), .IDX_W(IDX_W)) u_decode (
    .addr     (addr_q),
    .write    (write_q),
    .index    (dec_idx),
    .hi       (dec_hi),
    .legal    (dec_legal),
    .writable (dec_writable)
  );

  // Read-data selection for the EXEC cycle; a high read of the shadowed index returns the snapshot
  always_comb begin
    lo_sel     = lo_arr[dec_idx];
    hi_sel     = hi_arr[dec_idx];
    shadow_hit = shadow_vld_q && (shadow_idx_q == dec_idx);
    wr_en_d    = '0;
    wr_en_d[dec_idx] = 1'b1;
    if (!dec_legal || write_q) begin
      rdata_d = '0;
    end else if (!dec_hi) begin
      rdata_d = lo_sel;
    end else if (shadow_hit) begin
      rdata_d = shadow_q;
    end else begin
      rdata_d = hi_sel;
    end
  end

  // Port FSM, shadow and registered strobes; nothing advances while clk_en is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= 12'h000;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      wr_en_q      <= '0;
      wr_hi_q      <= 1'b0;
      wr_data_q    <= '0;
      shadow_q     <= '0;
      shadow_idx_q <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      wr_en_q   <= '0;
      wr_hi_q   <= 1'b0;
      wr_data_q <= '0;
      if (clk_en) begin
        case (state_q)
          IDLE: begin
            if (bus.req_valid) begin
              addr_q      <= bus.req_addr;
              write_q     <= bus.req_write;
              wdata_q     <= bus.req_wdata;
              req_ready_q <= 1'b0;
              state_q     <= EXEC;
            end
          end
          EXEC: begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= !dec_legal;
            state_q     <= RESP;
            if (write_q) begin
              shadow_vld_q <= 1'b0;
            end else if (dec_legal && !dec_hi) begin
              shadow_q     <= hi_sel;
              shadow_idx_q <= dec_idx;
              shadow_vld_q <= 1'b1;
            end else if (dec_legal && shadow_hit) begin
              shadow_vld_q <= 1'b0;
            end
            if (write_q && dec_writable) begin
              wr_en_q   <= wr_en_d;
              wr_hi_q   <= dec_hi;
              wr_data_q <= wdata_q;
            end
          end
          RESP: begin
            // First RESP cycle only raises valid, giving the two-cycle minimum latency
            if (!rsp_valid_q) begin
              rsp_valid_q <= 1'b1;
            end else if (bus.rsp_ready) begin
              rsp_valid_q <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
          default: begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign cnt_wr_en     = wr_en_q;
  assign cnt_wr_hi     = wr_hi_q;
  assign cnt_wr_data   = wr_data_q;

endmodule

// File: tb/tb_perf_csr_port.sv
// Scoreboard bench for perf_csr_port: expectations queued at issue time and
// popped when the response handshake completes.
module tb_perf_csr_port;
  import core_config_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [3:0]  en;
    logic        hi;
    logic [31:0] wd;
  } exp_t;

  typedef struct {
    int          lat;
    logic [31:0] data;
    logic        err;
    logic [3:0]  en;
    logic        hi;
    logic [31:0] wd;
    int          nstrobe;
    int          strobe_cyc;
    logic        stable;
    logic        idle_ready;
  } obs_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clk_en;
  logic [127:0] cnt_lo;
  logic [127:0] cnt_hi;
  logic [3:0]   cnt_wr_en;
  logic         cnt_wr_hi;
  logic [31:0]  cnt_wr_data;
  int           checks = 0;
  int           failures = 0;
  exp_t         sb_q[$];

  perf_csr_port_if bus();

  perf_csr_port #(.NUM_CNT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .bus         (bus.slave),
    .cnt_lo      (cnt_lo),
    .cnt_hi      (cnt_hi),
    .cnt_wr_en   (cnt_wr_en),
    .cnt_wr_hi   (cnt_wr_hi),
    .cnt_wr_data (cnt_wr_data)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [31:0] d, input logic er, input logic [3:0] en,
                          input logic hi, input logic [31:0] wd);
    exp_t e;
    e.data = d; e.err = er; e.en = en; e.hi = hi; e.wd = wd;
    sb_q.push_back(e);
  endtask

  // Issue one request, observe strobe/latency, optionally hold backpressure, then handshake
  task automatic run_req(input logic [11:0] a, input logic w, input logic [31:0] wd,
                         input int hold, output obs_t o);
    int waitc;
    o.lat = -1; o.data = '0; o.err = 1'b0; o.en = '0; o.hi = 1'b0; o.wd = '0;
    o.nstrobe = 0; o.strobe_cyc = -1; o.stable = 1'b1; o.idle_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_write = w; bus.req_wdata = wd;
    waitc = 0;
    while (bus.req_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (cnt_wr_en !== 4'b0000) begin
        o.nstrobe++; o.strobe_cyc = c; o.en = cnt_wr_en; o.hi = cnt_wr_hi; o.wd = cnt_wr_data;
      end
      if (bus.rsp_valid === 1'b1) begin
        o.lat = c;
        break;
      end
      @(negedge clk);
    end
    o.data = bus.rsp_rdata;
    o.err  = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      cnt_lo = {$urandom(), $urandom(), $urandom(), $urandom()};
      cnt_hi = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      if (bus.rsp_rdata !== o.data || bus.rsp_err !== o.err ||
          bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0) o.stable = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    o.idle_ready = (bus.req_ready === 1'b1) && (bus.rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs: req_ready=%b rsp_valid=%b expected 1/0", bus.req_ready, bus.rsp_valid);
    end
    checks++;
    if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: rdata=%h err=%b expected 0/0", bus.rsp_rdata, bus.rsp_err);
    end
    checks++;
    if (cnt_wr_en !== 4'b0000 || cnt_wr_hi !== 1'b0 || cnt_wr_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_strobe: en=%b hi=%b data=%h expected 0", cnt_wr_en, cnt_wr_hi, cnt_wr_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_cycle();
    obs_t o; exp_t e;
    cnt_lo[31:0] = 32'h0000_1234;
    push_exp(32'h0000_1234, 1'b0, 4'b0000, 1'b0, 32'h0);
    run_req(12'hC00, 1'b0, 32'h0, 0, o);
    e = sb_q.pop_front();
    checks++;
    if (o.lat !== 2 || o.data !== e.data || o.err !== e.err || o.nstrobe !== 0) begin
      failures++;
      $display("FAIL read_c00: lat=%0d data=%h err=%b strobes=%0d expected lat=2 data=%h err=%b strobes=0",
               o.lat, o.data, o.err, o.nstrobe, e.data, e.err);
    end
  endtask

  task automatic test_coherent();
    obs_t o; exp_t e;
    logic [11:0] addrs [3] = '{12'hC02, 12'hC82, 12'hC82};
    cnt_lo[95:64] = 32'hFFFF_FFFF;
    cnt_hi[95:64] = 32'h0000_0001;
    push_exp(32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b0, 32'h0);
    push_exp(32'h0000_0001, 1'b0, 4'b0000, 1'b0, 32'h0);
    push_exp(32'h0000_0002, 1'b0, 4'b0000, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      run_req(addrs[i], 1'b0, 32'h0, 0, o);
      if (i == 0) cnt_hi[95:64] = 32'h0000_0002;
      e = sb_q.pop_front();
      checks++;
      if (o.lat !== 2 || o.data !== e.data || o.err !== e.err) begin
        failures++;
        $display("FAIL coherent_%0d: lat=%0d data=%h err=%b expected lat=2 data=%h err=%b",
                 i, o.lat, o.data, o.err, e.data, e.err);
      end
    end
  endtask

  task automatic test_mach_write();
    obs_t o; exp_t e;
    logic [11:0] addrs [5] = '{12'hB80, 12'hB02, 12'hC03, 12'hB00, 12'hC83};
    logic        wrs   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] wds   [5] = '{32'hDEAD_BEEF, 32'h0000_0055, 32'h0, 32'h0000_0099, 32'h0};
    cnt_lo[127:96] = 32'h0000_0003;
    cnt_hi[127:96] = 32'h0000_0033;
    push_exp(32'h0, 1'b0, 4'b0001, 1'b1, 32'hDEAD_BEEF);
    push_exp(32'h0, 1'b0, 4'b0100, 1'b0, 32'h0000_0055);
    push_exp(32'h0000_0003, 1'b0, 4'b0000, 1'b0, 32'h0);
    push_exp(32'h0, 1'b0, 4'b0001, 1'b0, 32'h0000_0099);
    push_exp(32'h0000_0044, 1'b0, 4'b0000, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      run_req(addrs[i], wrs[i], wds[i], 0, o);
      if (i == 2) cnt_hi[127:96] = 32'h0000_0044;
      e = sb_q.pop_front();
      checks++;
      if (o.lat !== 2 || o.data !== e.data || o.err !== e.err) begin
        failures++;
        $display("FAIL mwrite_rsp_%0d: lat=%0d data=%h err=%b expected lat=2 data=%h err=%b",
                 i, o.lat, o.data, o.err, e.data, e.err);
      end
      checks++;
      if (o.en !== e.en || o.nstrobe !== ((e.en != 4'b0000) ? 1 : 0) ||
          (e.en != 4'b0000 && (o.hi !== e.hi || o.wd !== e.wd || o.strobe_cyc !== 1))) begin
        failures++;
        $display("FAIL mwrite_strobe_%0d: en=%b hi=%b data=%h n=%0d cyc=%0d expected en=%b hi=%b data=%h n=1 cyc=1",
                 i, o.en, o.hi, o.wd, o.nstrobe, o.strobe_cyc, e.en, e.hi, e.wd);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o; exp_t e;
    logic [11:0] addrs [5] = '{12'hC00, 12'hB01, 12'hC04, 12'h123, 12'hB81};
    logic        wrs   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      push_exp(32'h0, 1'b1, 4'b0000, 1'b0, 32'h0);
      run_req(addrs[i], wrs[i], 32'hA5A5_A5A5, 0, o);
      e = sb_q.pop_front();
      checks++;
      if (o.lat !== 2 || o.data !== e.data || o.err !== e.err || o.nstrobe !== 0) begin
        failures++;
        $display("FAIL illegal_%h: lat=%0d data=%h err=%b strobes=%0d expected lat=2 data=0 err=1 strobes=0",
                 addrs[i], o.lat, o.data, o.err, o.nstrobe);
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o; exp_t e;
    cnt_lo[63:32] = 32'hAAAA_5555;
    push_exp(32'hAAAA_5555, 1'b0, 4'b0000, 1'b0, 32'h0);
    run_req(12'hC01, 1'b0, 32'h0, 5, o);
    e = sb_q.pop_front();
    checks++;
    if (o.data !== e.data || o.err !== e.err || o.stable !== 1'b1) begin
      failures++;
      $display("FAIL backpressure: data=%h err=%b stable=%b expected data=%h err=0 stable=1",
               o.data, o.err, o.stable, e.data);
    end
    checks++;
    if (o.idle_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back: idle_ready=%b expected 1 after handshake", o.idle_ready);
    end
  endtask

  task automatic test_clk_en();
    exp_t e;
    logic quiet = 1'b1;
    push_exp(32'h0, 1'b0, 4'b1000, 1'b0, 32'h0000_0077);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 12'hB03; bus.req_write = 1'b1; bus.req_wdata = 32'h0000_0077;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (cnt_wr_en !== 4'b0000 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      failures++;
      $display("FAIL clken_hold: strobe or response while clk_en low, got quiet=%b expected 1", quiet);
    end
    clk_en = 1'b1;
    e = sb_q.pop_front();
    @(negedge clk);
    checks++;
    if (cnt_wr_en !== e.en || cnt_wr_hi !== e.hi || cnt_wr_data !== e.wd) begin
      failures++;
      $display("FAIL clken_strobe: en=%b hi=%b data=%h expected en=%b hi=%b data=%h",
               cnt_wr_en, cnt_wr_hi, cnt_wr_data, e.en, e.hi, e.wd);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== e.err || bus.rsp_rdata !== e.data || cnt_wr_en !== 4'b0000) begin
      failures++;
      $display("FAIL clken_rsp: valid=%b err=%b data=%h en=%b expected 1/0/%h/0000",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, cnt_wr_en, e.data);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    obs_t o; exp_t e;
    cnt_lo[31:0] = 32'h0000_0005;
    cnt_hi[31:0] = 32'h0000_00A0;
    push_exp(32'h0000_0005, 1'b0, 4'b0000, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 12'hC00; bus.req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.data) begin
      failures++;
      $display("FAIL midop_pre: valid=%b data=%h expected 1/%h", bus.rsp_valid, bus.rsp_rdata, e.data);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || cnt_wr_en !== 4'b0000) begin
      failures++;
      $display("FAIL midop_reset: valid=%b ready=%b en=%b expected 0/1/0000",
               bus.rsp_valid, bus.req_ready, cnt_wr_en);
    end
    rst_n = 1'b1;
    cnt_hi[31:0] = 32'h0000_00B0;
    push_exp(32'h0000_00B0, 1'b0, 4'b0000, 1'b0, 32'h0);
    run_req(12'hC80, 1'b0, 32'h0, 0, o);
    e = sb_q.pop_front();
    checks++;
    if (o.lat !== 2 || o.data !== e.data || o.err !== e.err) begin
      failures++;
      $display("FAIL midop_shadow: lat=%0d data=%h err=%b expected lat=2 data=%h err=0",
               o.lat, o.data, o.err, e.data);
    end
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = 12'h000; bus.req_write = 1'b0;
    bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
    cnt_lo = '0; cnt_hi = '0;
    test_reset();
    test_read_cycle();
    test_coherent();
    test_mach_write();
    test_illegal();
    test_backpressure();
    test_clk_en();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_csr_port.md
# perf_csr_port

CSR-side access port for the core's performance counter bank. It accepts CSR read and write requests from the execute stage over a valid/ready handshake and returns the requested 32-bit half of a 64-bit counter. Each counter instance supplies its value on `outL`/`outH`. The port also drives load strobes back into the counters for machine-mode writes. Between a low-half read and the matching high-half read, it holds a high-half shadow so that software sees a coherent 64-bit value.

## Interface
- `NUM_CNT`, default 4: number of counters; index 0 = cycle, 1 = time, 2 = instret, 3+ = hpmcounter3..
- `clk` in 1: core clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `clk_en` in 1: global clock enable. When low, all state is frozen and strobes are forced low.
- `req_valid` in 1: CSR request valid.
- `req_ready` out 1: port can accept a request.
- `req_addr` in 12: CSR address.
- `req_write` in 1: 1 = write, 0 = read.
- `req_wdata` in XLEN: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out XLEN: read data. Value is 0 on error and 0 for writes.
- `rsp_err` out 1: illegal access.
- `cnt_lo` in NUM_CNT*XLEN: packed `outL` of each counter; index i occupies bits [i*XLEN +: XLEN].
- `cnt_hi` in NUM_CNT*XLEN: packed `outH` of each counter.
- `cnt_wr_en` out NUM_CNT: one-hot load strobe.
- `cnt_wr_hi` out 1: 1 = load the high half, 0 = load the low half.
- `cnt_wr_data` out XLEN: load value.

## Operation
- **Address map** (i < NUM_CNT):
  - 0xC00+i: user low half, read-only.
  - 0xC80+i: user high half, read-only.
  - 0xB00+i: machine low half, read/write.
  - 0xB80+i: machine high half, read/write.
  - 0xB01 and 0xB81 (mtime) are illegal.
  - Any other address, or any i ≥ NUM_CNT, is illegal.
- **Illegal accesses:** writing a 0xCxx address, or any access to an illegal address, gives `rsp_err`=1, `rsp_rdata`=0 and no strobe.
- **FSM**, states IDLE, EXEC, RESP. Transitions occur only when `clk_en`=1.
  - **IDLE:** `req_ready`=1. On `req_valid`, register addr/write/wdata and go to EXEC.
  - **EXEC:** decode the address.
    - Read: latch the selected half into the response register.
    - Legal write: assert `cnt_wr_en[i]`, `cnt_wr_hi` and `cnt_wr_data`=wdata for exactly this cycle.
    - Go to RESP.
  - **RESP:** `rsp_valid`=1, with data and err stable. On `rsp_ready`, go to IDLE. There is no request/response overlap.
- **Coherence shadow** (one register plus an index plus a valid bit):
  - A low-half read of index i (0xC00+i or 0xB00+i) captures `cnt_hi[i]` in the same EXEC cycle and sets the shadow valid with index i.
  - A following high-half read of the same index returns the shadow value and clears valid.
  - A high-half read with the shadow invalid or with a different index returns live `cnt_hi[i]`.
  - Any write clears the shadow.
- **Write priority:** a counter load strobe has priority over that counter's increment in the same cycle (counter-side contract). The written value is visible on `cnt_lo`/`cnt_hi` on the next cycle.

## Timing
- **Reset values:**
  - State = IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `cnt_wr_en`=0, `cnt_wr_hi`=0, `cnt_wr_data`=0.
  - Shadow valid = 0.
- **Latency:** a request accepted at edge N raises `rsp_valid` after edge N+2 (minimum 2 cycles). The write strobe is high during the cycle between edge N+1 and edge N+2.
- **Back-to-back:** the next request is accepted at the earliest one cycle after the response handshake (`req_ready` is high only in IDLE).
- **`clk_en` low:** state, shadow and response are held; strobes are 0. An EXEC cycle with `clk_en`=0 does not fire a strobe and does not advance.
- **Reset mid-operation:** a pending response is dropped, the shadow is cleared, and an EXEC-cycle strobe is suppressed (`cnt_wr_en`=0 during reset).
- **Response stability:** while `rsp_valid`=1 and `rsp_ready`=0, `rsp_rdata`/`rsp_err` do not change even if the counters change.

## Structure
- Add to `core_config_pkg`:
  - CSR base constants (CSR_CNT_U_LO=12'hC00, CSR_CNT_U_HI=12'hC80, CSR_CNT_M_LO=12'hB00, CSR_CNT_M_HI=12'hB80).
  - `perf_port_state_t` enum {IDLE, EXEC, RESP}.
  - Reuse the existing XLEN and PERF_CNT_LEN.
- One sub-module: `perf_csr_decode`, combinational. Inputs: addr, write. Outputs: index, hi, legal, writable.

## Test plan
- **Read, cycle low:** `cnt_lo[0]`=32'h0000_1234, read 0xC00 → `rsp_valid` 2 cycles after accept, `rsp_rdata`=32'h0000_1234, `rsp_err`=0.
- **Coherent split read:**
  - Start with counter 2 = 64'h0000_0001_FFFF_FFFF.
  - Read 0xC02, which returns FFFF_FFFF.
  - Bench then changes `cnt_hi[2]` to 2.
  - Read 0xC82 → returns 32'h0000_0001 (shadow).
  - A second read of 0xC82 → returns 32'h0000_0002 (live).
- **Machine write:** write 0xB80 with 32'hDEAD_BEEF → single-cycle `cnt_wr_en`=4'b0001, `cnt_wr_hi`=1, `cnt_wr_data`=DEAD_BEEF; `rsp_err`=0, `rsp_rdata`=0.
- **Illegal accesses:** each of the following gives `rsp_err`=1 with no strobe:
  - write 0xC00;
  - read 0xB01;
  - read 0xC04 with NUM_CNT=4.
- **Backpressure and `clk_en`:**
  - Hold `rsp_ready`=0 for 5 cycles while the counters change → `rsp_rdata` stays stable and `req_ready`=0.
  - Drop `clk_en` during EXEC → no strobe until `clk_en` returns.
- **Reset mid-op:** assert `rst_n`=0 during RESP → next cycle `rsp_valid`=0, `req_ready`=1, shadow cleared (a subsequent 0xC80 read returns live `cnt_hi[0]`).
